icache_sram_like: RTL and testbench

- Direct-mapped, read-only instruction cache.
- Sits between the core's instruction sram-like port (physical address, after the mmu) and the instruction sram-like port of cpu_axi_interface.
- Hits are served from internal register arrays with 1-cycle latency.
- Misses refill a whole line as sequential single-word sram-like reads.
- Uncached fetches (kseg1) bypass the arrays.

---
 rtl/icache_sram_like.sv | 183 ++++++++++++++++++
 tb/tb_icache_sram_like.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_sram_like.sv
// Direct-mapped read-only instruction cache between the core fetch port
// and the sram-like instruction port of the AXI bridge.
module icache_sram_like #(
  parameter int INDEX_BITS  = 7,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  input  logic        inv_all,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REF_REQ,
    S_REF_WAIT,
    S_REF_DONE,
    S_UNC_REQ,
    S_UNC_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q;
  logic [31:0]            addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic                   unc_q, unc_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   inv_q, inv_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [31:0]            data_q [LINES][WORDS];

  logic [INDEX_BITS-1:0]  idx;
  logic [OFFSET_BITS-1:0] word;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic                   fill_we;
  logic                   unused_ok;

  assign idx  = addr_q[2+OFFSET_BITS +: INDEX_BITS];
  assign word = addr_q[2 +: OFFSET_BITS];
  assign tag  = addr_q[31 -: TAG_BITS];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag) && !unc_q;

  assign mem_wr    = 1'b0;
  assign mem_wdata = 32'h0;
  assign unused_ok = ^{cpu_wr, cpu_wdata};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    unc_d       = unc_q;
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    cpu_data_ok = 1'b0;
    cpu_rdata   = 32'h0;
    mem_req     = 1'b0;
    mem_size    = 2'b10;
    mem_addr    = 32'h0;
    fill_we     = 1'b0;
    cpu_addr_ok = ready_q &&
                  (state_q == S_IDLE || (state_q == S_LOOKUP && hit));

    unique case (state_q)
      S_IDLE: ;
      S_LOOKUP: begin
        if (unc_q) begin
          state_d = S_UNC_REQ;
        end else if (hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = data_q[idx][word];
          state_d     = S_IDLE;
        end else begin
          state_d = S_REF_REQ;
          cnt_d   = '0;
          inv_d   = 1'b0;
        end
      end
      S_REF_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, cnt_q, 2'b00};
        if (mem_addr_ok) state_d = S_REF_WAIT;
      end
      S_REF_WAIT: begin
        if (mem_data_ok) begin
          fill_we = 1'b1;
          if (cnt_q == OFFSET_BITS'(WORDS - 1)) begin
            state_d = S_REF_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_REF_REQ;
          end
        end
      end
      S_REF_DONE: begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = data_q[idx][word];
        state_d     = S_IDLE;
      end
      S_UNC_REQ: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        mem_size = size_q;
        if (mem_addr_ok) state_d = S_UNC_WAIT;
      end
      S_UNC_WAIT: begin
        if (mem_data_ok) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = mem_rdata;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // an invalidate seen mid-refill keeps the new line from going valid
    if (inv_all && (state_q == S_REF_REQ || state_q == S_REF_WAIT ||
                    state_q == S_REF_DONE))
      inv_d = 1'b1;

    if (cpu_req && cpu_addr_ok) begin
      addr_d  = cpu_addr;
      size_d  = cpu_size;
      unc_d   = cpu_uncached;
      state_d = S_LOOKUP;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      unc_q   <= 1'b0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      addr_q  <= addr_d;
      size_q  <= size_d;
      unc_q   <= unc_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      if (inv_all)
        valid_q <= '0;
      else if (state_q == S_REF_DONE && !inv_q)
        valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)
      data_q[idx][cnt_q] <= mem_rdata;
    if (state_q == S_REF_DONE)
      tag_q[idx] <= tag;
  end

endmodule

// File: tb/tb_icache_sram_like.sv
// Directed bench for icache_sram_like: vector table plus
// hand sequences for backpressure, invalidation and reset.
module tb_icache_sram_like;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_uncached = 1'b0;
  logic        inv_all = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_addr_ok;
  logic        mem_data_ok = 1'b0;
  logic        aok_en = 1'b1;

  always #5 clk = ~clk;
  assign mem_addr_ok = mem_req & aok_en;

  icache_sram_like dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_uncached(cpu_uncached), .inv_all(inv_all),
    .cpu_rdata(cpu_rdata), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] dq[$];
  int          dc[$];
  logic [31:0] hq[$];
  logic [1:0]  sq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn && cpu_data_ok) begin
      dq.push_back(cpu_rdata);
      dc.push_back(cyc);
    end
    if (mem_req && mem_addr_ok) begin
      hq.push_back(mem_addr);
      sq.push_back(mem_size);
    end
  end

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a[31:4] == 28'h1FC0000)
      return 32'h11 * ({30'b0, a[3:2]} + 32'd1);
    return a ^ 32'hDEAD0000;
  endfunction

  logic        r_hs;
  logic [31:0] r_ha;
  initial begin
    forever begin
      @(negedge clk);
      r_hs = mem_req && mem_addr_ok;
      r_ha = mem_addr;
      @(posedge clk);
      #1;
      mem_data_ok = r_hs;
      mem_rdata   = r_hs ? memval(r_ha) : 32'h0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic fetch(input logic [31:0] a, input logic unc,
                       input logic [1:0] sz, output logic [31:0] d,
                       output int lat);
    int  n0, acc;
    bit  ok;
    n0  = dq.size();
    d   = 32'hBADBAD00;
    lat = -1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; cpu_uncached = unc; cpu_size = sz;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (cpu_addr_ok) ok = 1;
    end
    acc = cyc;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!ok) begin
      timeout("accept");
      return;
    end
    for (int i = 0; i < 100 && dq.size() == n0; i++) begin
      @(negedge clk); #1;
    end
    if (dq.size() > n0) begin
      d   = dq[n0];
      lat = dc[n0] - acc;
    end else begin
      timeout("data_ok");
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        unc;
    logic [1:0]  sz;
    logic [31:0] data;
    int          lat;
    int          nreq;
  } vec_t;

  vec_t tv[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, a0;
    int lat, h0, n0, okc;
    bit seen, stable;

    tv[0] = '{32'h1FC0_0004, 1'b0, 2'b00, 32'h22,        10, 4};
    tv[1] = '{32'h1FC0_0008, 1'b0, 2'b00, 32'h33,         1, 0};
    tv[2] = '{32'h1FC0_000C, 1'b0, 2'b00, 32'h44,         1, 0};
    tv[3] = '{32'h1FC0_0800, 1'b0, 2'b00, 32'hC16D_0800, 10, 4};
    tv[4] = '{32'h1FC0_080C, 1'b0, 2'b00, 32'hC16D_080C,  1, 0};
    tv[5] = '{32'h1FC0_0000, 1'b0, 2'b00, 32'h11,        10, 4};
    tv[6] = '{32'h1FC0_0010, 1'b1, 2'b10, 32'hC16D_0010,  3, 1};
    tv[7] = '{32'h1FC0_0010, 1'b0, 2'b00, 32'hC16D_0010, 10, 4};
    tv[8] = '{32'h1FC0_0014, 1'b1, 2'b01, 32'hC16D_0014,  3, 1};

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_addr_ok", {31'b0, cpu_addr_ok}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    resetn = 1'b1;
    #1;
    chk("addr_ok_pre_edge", {31'b0, cpu_addr_ok}, 32'd0);
    @(negedge clk); #1;
    chk("addr_ok_post_rst", {31'b0, cpu_addr_ok}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      h0 = hq.size();
      fetch(tv[i].addr, tv[i].unc, tv[i].sz, d, lat);
      chk($sformatf("v%0d_data", i), d, tv[i].data);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_nreq", i), hq.size() - h0, tv[i].nreq);
      if (tv[i].nreq > 0 && hq.size() > h0)
        chk($sformatf("v%0d_size", i), {30'b0, sq[sq.size()-1]},
            {30'b0, tv[i].unc ? tv[i].sz : 2'b10});
      if (tv[i].nreq > 1 && hq.size() >= h0 + tv[i].nreq)
        for (int k = 0; k < tv[i].nreq; k++)
          chk($sformatf("v%0d_addr%0d", i, k), hq[h0+k],
              {tv[i].addr[31:4], 4'h0} + 32'(4 * k));
    end

    h0 = hq.size();
    n0 = dq.size();
    okc = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_uncached = 1'b0; cpu_size = 2'b10;
    for (int k = 0; k < 4; k++) begin
      cpu_addr = 32'h1FC0_0000 + 32'(4 * k);
      @(negedge clk); #1;
      if (cpu_addr_ok) okc++;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_addr_ok", okc, 4);
    chk("b2b_count", dq.size() - n0, 4);
    chk("b2b_nreq", hq.size() - h0, 0);
    if (dq.size() >= n0 + 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b_data%0d", k), dq[n0+k], 32'h11 * (k + 1));
        chk($sformatf("b2b_cyc%0d", k), dc[n0+k] - dc[n0], k);
      end

    h0 = hq.size();
    aok_en = 1'b0;
    fork
      fetch(32'h1FC0_0020, 1'b0, 2'b00, d, lat);
      begin
        seen = 0;
        for (int w = 0; w < 30 && !seen; w++) begin
          @(negedge clk); #1;
          if (mem_req) seen = 1;
        end
        if (!seen) timeout("stall_req");
        a0 = mem_addr;
        stable = 1;
        repeat (4) begin
          @(negedge clk); #1;
          if (!mem_req || mem_addr !== a0) stable = 0;
        end
        chk("stall_addr", a0, 32'h1FC0_0020);
        chk("stall_stable", {31'b0, stable}, 32'd1);
        @(posedge clk); #1;
        aok_en = 1'b1;
        @(posedge clk); #1;
        inv_all = 1'b1;
        @(posedge clk); #1;
        inv_all = 1'b0;
      end
    join
    aok_en = 1'b1;
    chk("bp_data", d, 32'hC16D_0020);
    chk("bp_nreq", hq.size() - h0, 4);
    fetch(32'h1FC0_0020, 1'b0, 2'b00, d, lat);
    chk("inv_refetch_data", d, 32'hC16D_0020);
    chk("inv_refetch_lat", lat, 10);

    fetch(32'h1FC0_0004, 1'b0, 2'b00, d, lat);
    chk("pre_rst_miss", lat, 10);
    fetch(32'h1FC0_0008, 1'b0, 2'b00, d, lat);
    chk("pre_rst_hit_lat", lat, 1);
    chk("pre_rst_hit_data", d, 32'h33);

    n0 = dq.size();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h1FC0_0030; cpu_uncached = 1'b0;
    seen = 0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk); #1;
      if (cpu_addr_ok) seen = 1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!seen) timeout("rst_accept");
    seen = 0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk); #1;
      if (mem_req) seen = 1;
    end
    if (!seen) timeout("rst_mem_req_wait");
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_data_ok", {31'b0, cpu_data_ok}, 32'd0);
    chk("midrst_addr_ok", {31'b0, cpu_addr_ok}, 32'd0);
    chk("midrst_rdata", cpu_rdata, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("midrst_addr_ok_pre", {31'b0, cpu_addr_ok}, 32'd0);
    @(negedge clk); #1;
    chk("midrst_addr_ok_post", {31'b0, cpu_addr_ok}, 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("midrst_no_data", dq.size() - n0, 0);
    fetch(32'h1FC0_0008, 1'b0, 2'b00, d, lat);
    chk("post_rst_lat", lat, 10);
    chk("post_rst_data", d, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
